// File: rtl/keypad_encoder.sv
// keypad_encoder: synchronises and debounces three raw vault buttons, rejects
// multi-button chords and emits one registered 2-bit key code per accepted press.
// Optional feature: define KEYPAD_TIMEOUT_EN to build the post-key inactivity timeout.
module keypad_encoder #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_W           = 16,
    parameter int unsigned TIMEOUT_CYCLES  = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] btn,
    output logic [1:0] code,
    output logic       key_valid,
    output logic       key_err,
    output logic       timeout
);

    localparam int unsigned BTN_W  = 3;
    localparam int unsigned CODE_W = 2;
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Reject parameter sets the counters cannot represent.
    if (DEBOUNCE_CYCLES < 1 || $clog2(DEBOUNCE_CYCLES) > CNT_W ||
        TIMEOUT_CYCLES < 1 || $clog2(TIMEOUT_CYCLES) > CNT_W) begin : g_bad_params
        $error("keypad_encoder: CNT_W too narrow or cycle counts below 1");
    end

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DEBOUNCE = 3'd1,
        EMIT     = 3'd2,
        REJECT   = 3'd3,
        RELEASE  = 3'd4
    } state_e;

    logic [BTN_W-1:0]  sync1_q, sync1_d;
    logic [BTN_W-1:0]  btn_s_q, btn_s_d;
    state_e            state_q, state_d;
    logic [BTN_W-1:0]  cand_q, cand_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic              key_valid_q, key_valid_d;
    logic              key_err_q, key_err_d;

    // Single-button pattern to key code; chords never reach this.
    function automatic logic [CODE_W-1:0] enc(input logic [BTN_W-1:0] v);
        logic [CODE_W-1:0] c;
        c = '0;
        case (v)
            3'b001:  c = 2'b01;
            3'b010:  c = 2'b10;
            3'b100:  c = 2'b11;
            default: c = 2'b00;
        endcase
        return c;
    endfunction

    // True when exactly one button is pressed.
    function automatic logic is_one_hot(input logic [BTN_W-1:0] v);
        return (v != '0) && ((v & (v - BTN_W'(1))) == '0);
    endfunction

    // Two-flop synchroniser inputs; raw btn is used nowhere else.
    always_comb begin
        sync1_d = btn;
        btn_s_d = sync1_q;
    end

    // Synchroniser chain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= '0;
            btn_s_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            btn_s_q <= btn_s_d;
        end
    end

    // Next state, counter, candidate and registered outputs (set on entry to EMIT/REJECT).
    always_comb begin
        state_d     = state_q;
        cand_d      = cand_q;
        cnt_d       = cnt_q;
        code_d      = '0;
        key_valid_d = 1'b0;
        key_err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (btn_s_q != '0) begin
                    state_d = DEBOUNCE;
                    cand_d  = btn_s_q;
                    cnt_d   = '0;
                end
            end
            DEBOUNCE: begin
                if (btn_s_q != cand_q) begin
                    state_d = IDLE;
                end else if (cnt_q == DB_LAST) begin
                    if (is_one_hot(cand_q)) begin
                        state_d     = EMIT;
                        code_d      = enc(cand_q);
                        key_valid_d = 1'b1;
                    end else begin
                        state_d   = REJECT;
                        key_err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            EMIT: begin
                state_d = RELEASE;
                cnt_d   = '0;
            end
            REJECT: begin
                state_d = RELEASE;
                cnt_d   = '0;
            end
            RELEASE: begin
                if (btn_s_q != '0) begin
                    cnt_d = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cand_q      <= '0;
            cnt_q       <= '0;
            code_q      <= '0;
            key_valid_q <= 1'b0;
            key_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            code_q      <= code_d;
            key_valid_q <= key_valid_d;
            key_err_q   <= key_err_d;
        end
    end

    assign code      = code_q;
    assign key_valid = key_valid_q;
    assign key_err   = key_err_q;

`ifdef KEYPAD_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic             armed_q, armed_d;
    logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
    logic             timeout_q, timeout_d;

    // Armed by each accepted key; counts IDLE cycles only and fires once per idle period.
    always_comb begin
        armed_d    = armed_q;
        idle_cnt_d = idle_cnt_q;
        timeout_d  = 1'b0;
        if (key_valid_d) begin
            armed_d    = 1'b1;
            idle_cnt_d = '0;
        end else if (armed_q && (state_q == IDLE)) begin
            if (idle_cnt_q == TO_LAST) begin
                timeout_d  = 1'b1;
                armed_d    = 1'b0;
                idle_cnt_d = '0;
            end else begin
                idle_cnt_d = idle_cnt_q + CNT_W'(1);
            end
        end
    end

    // Timeout registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            armed_q    <= 1'b0;
            idle_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            armed_q    <= armed_d;
            idle_cnt_q <= idle_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_keypad_encoder.sv
// tb_keypad_encoder: directed and random button sequences checked edge by edge
// against a run-length reference model of the keypad encoder.
module tb_keypad_encoder;

    localparam int DB   = 4;
`ifdef KEYPAD_TIMEOUT_EN
    localparam int TO   = 50;
`else
    localparam int TO   = 1000;
`endif
    localparam int MAXL = 256;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] btn = 3'b000;
    logic [1:0] code;
    logic       key_valid;
    logic       key_err;
    logic       timeout;

    keypad_encoder #(
        .DEBOUNCE_CYCLES(DB),
        .CNT_W(16),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn(btn),
        .code(code),
        .key_valid(key_valid),
        .key_err(key_err),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    logic [2:0] stim [MAXL];
    int         stim_len;
    logic [4:0] expv [MAXL];   // {code, key_valid, key_err, timeout} after each edge
    int         seg_valid, seg_err, seg_to, first_valid_edge;

    task automatic clear_stim();
        stim_len = 0;
    endtask

    task automatic push(input logic [2:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            stim[stim_len] = v;
            stim_len++;
        end
    endtask

    function automatic logic [1:0] model_code(input logic [2:0] v);
        for (int i = 0; i < 3; i++)
            if (v == 3'(1 << i)) return 2'(i + 1);
        return 2'b00;
    endfunction

    // Reference: scan the synchronised sample stream (btn delayed by three edges)
    // by run lengths: a press needs DB+1 matching samples, a release DB zero samples.
    task automatic build_expected();
        logic [2:0] s [MAXL];
        bit         idle [MAXL];
        int         last, t, m, r, cnt;
        bit         ok, armed;
        last = stim_len + 2;
        for (int e = 0; e < MAXL; e++) begin
            s[e]    = (e >= 3 && (e - 3) < stim_len) ? stim[e - 3] : 3'b000;
            expv[e] = 5'b0;
            idle[e] = 1'b0;
        end
        t = 1;
        while (t <= last) begin
            idle[t] = 1'b1;
            if (s[t] == 3'b000) begin
                t++;
            end else begin
                m = t + 1;
                while (m <= t + DB && s[m] == s[t]) m++;
                if (m <= t + DB) begin
                    t = m + 1;
                end else begin
                    if ($countones(s[t]) == 1) expv[t + DB] = {model_code(s[t]), 3'b100};
                    else                       expv[t + DB] = 5'b00010;
                    r = t + 2 * DB + 1;
                    while (r < MAXL - 1) begin
                        ok = 1'b1;
                        for (int k = 0; k < DB; k++) if (s[r - k] != 3'b000) ok = 1'b0;
                        if (ok) break;
                        r++;
                    end
                    t = r + 1;
                end
            end
        end
`ifdef KEYPAD_TIMEOUT_EN
        armed = 1'b0;
        cnt   = 0;
        for (int e = 1; e <= last; e++) begin
            if (expv[e][2]) begin
                armed = 1'b1;
                cnt   = 0;
            end else if (armed && idle[e]) begin
                cnt++;
                if (cnt == TO) begin
                    expv[e][0] = 1'b1;
                    armed      = 1'b0;
                end
            end
        end
`else
        armed = 1'b0;
        cnt   = 0;
`endif
    endtask

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Reset (checking outputs clear asynchronously), then replay stim edge by edge.
    task automatic run_seg(input string tag);
        int last;
        build_expected();
        last = stim_len + 2;
        rst = 1'b0;
        #1;
        check_eq({tag, "_async_reset"}, {3'b000, code, key_valid, key_err, timeout}, 8'h00);
        btn = (stim_len > 0) ? stim[0] : 3'b000;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        seg_valid = 0;
        seg_err = 0;
        seg_to = 0;
        first_valid_edge = -1;
        for (int e = 1; e <= last; e++) begin
            @(posedge clk);
            #1;
            btn = (e < stim_len) ? stim[e] : 3'b000;
            @(negedge clk);
            check_eq($sformatf("%s_edge%0d", tag, e),
                     {3'b000, code, key_valid, key_err, timeout}, {3'b000, expv[e]});
            if (key_valid) begin
                seg_valid++;
                if (first_valid_edge < 0) first_valid_edge = e;
            end
            if (key_err) seg_err++;
            if (timeout) seg_to++;
        end
    endtask

    task automatic check_counts(input string tag, input int v, input int er, input int to);
        check_eq({tag, "_valid_count"}, 8'(seg_valid), 8'(v));
        check_eq({tag, "_err_count"},   8'(seg_err),   8'(er));
        check_eq({tag, "_to_count"},    8'(seg_to),    8'(to));
    endtask

    initial begin
        logic [2:0] v;
        int         sel;
        #2;
        // Reset lands mid-DEBOUNCE, then while code is showing a key.
        clear_stim(); push(3'b001, 3);
        run_seg("t1_mid_debounce");      check_counts("t1_mid_debounce", 0, 0, 0);
        clear_stim(); push(3'b001, 5);
        run_seg("t1_at_emit");           check_counts("t1_at_emit", 1, 0, 0);
        // Button held through reset release and for 20 cycles: one key, fixed latency.
        clear_stim(); push(3'b001, 20); push(3'b000, 4);
        run_seg("t2_held");              check_counts("t2_held", 1, 0, 0);
        check_eq("t2_latency", 8'(first_valid_edge), 8'(1 + DB + 2));
        // Short pulse ignored, later steady press accepted.
        clear_stim(); push(3'b010, 2); push(3'b000, 6); push(3'b010, 10); push(3'b000, 4);
        run_seg("t3_pulse");             check_counts("t3_pulse", 1, 0, 0);
        // Chord rejected, then a single button accepted.
        clear_stim(); push(3'b101, 10); push(3'b000, 6); push(3'b100, 10); push(3'b000, 4);
        run_seg("t4_chord");             check_counts("t4_chord", 1, 1, 0);
        // Two presses with a gap of exactly DB cycles.
        clear_stim(); push(3'b001, 8); push(3'b000, DB); push(3'b001, 8); push(3'b000, 4);
        run_seg("t5_two_press");         check_counts("t5_two_press", 2, 0, 0);
        // Release glitch shorter than DB.
        clear_stim(); push(3'b001, 8); push(3'b000, DB - 2); push(3'b001, 8); push(3'b000, 4);
        run_seg("t5_glitch");            check_counts("t5_glitch", 1, 0, 0);
        // Chord forming during debounce restarts and is rejected.
        clear_stim(); push(3'b001, 2); push(3'b011, 10); push(3'b000, 6);
        run_seg("chord_forming");        check_counts("chord_forming", 0, 1, 0);
        // Partial release of an accepted chord never emits.
        clear_stim(); push(3'b011, 10); push(3'b001, 10); push(3'b000, 6);
        run_seg("partial_release");      check_counts("partial_release", 0, 1, 0);
        // Long idle with no key since reset.
        clear_stim(); push(3'b000, 70);
        run_seg("idle_no_key");          check_counts("idle_no_key", 0, 0, 0);
        // One key followed by a long idle period.
        clear_stim(); push(3'b001, 8); push(3'b000, 80);
`ifdef KEYPAD_TIMEOUT_EN
        run_seg("t6_timeout");           check_counts("t6_timeout", 1, 0, 1);
`else
        run_seg("t6_timeout");           check_counts("t6_timeout", 1, 0, 0);
`endif
        // Random runs of idle, single buttons and chords.
        for (int n = 0; n < 8; n++) begin
            clear_stim();
            while (stim_len < 60) begin
                sel = int'($urandom_range(0, 9));
                if (sel < 4)      v = 3'b000;
                else if (sel < 7) v = 3'(1 << $urandom_range(0, 2));
                else              v = 3'($urandom_range(1, 7));
                push(v, int'($urandom_range(1, 7)));
            end
            push(3'b000, 8);
            run_seg($sformatf("rand%0d", n));
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
